// File: rtl/bias_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bias_load_ctrl_pkg
// Brief    : Shared FSM state type and width helpers for the bias load path.
// Revision : 1.0 - initial release
// ============================================================================
package bias_load_ctrl_pkg;

  localparam int DEF_SIZE       = 16;
  localparam int DEF_BUS_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  localparam int ROW_W = $clog2(DEF_SIZE);
  localparam int BYTES = DEF_BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CFG   = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } bias_state_e;

  function automatic int row_w(input int size);
    return $clog2(size);
  endfunction

  function automatic int word_bytes(input int bus_width);
    return bus_width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bias_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bias_load_ctrl
// Brief    : Fetches one tile of bias words from memory into the adder's
//            double-buffered bias store, tracking free buffers with credits.
// Revision : 1.0 - initial release
// ============================================================================
module bias_load_ctrl
  import bias_load_ctrl_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]    cmd_bias_addr_i,
  input  logic [$clog2(SIZE)-1:0]  cmd_row_num_i,
  input  logic                     cmd_need_bias_i,
  output logic                     mem_req_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [BUS_WIDTH-1:0]     mem_rdata_i,
  output logic                     init_bias_cfg_o,
  output logic [$clog2(SIZE)-1:0]  valid_row_num_o,
  output logic                     need_bias_o,
  output logic                     bias_wr_en_o,
  output logic [$clog2(SIZE)-1:0]  bias_wr_addr_o,
  output logic [BUS_WIDTH-1:0]     bias_data_o,
  input  logic                     bias_loading_done_i,
  output logic                     tile_loaded_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int RW = row_w(SIZE);
  localparam int NB = word_bytes(BUS_WIDTH);

  bias_state_e           state_q, state_d;
  logic [1:0]            credits_q, credits_d;
  logic                  ready_q;
  logic                  cfg_q;
  logic                  tile_q;
  logic                  need_q;
  logic                  wr_en_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [RW-1:0]         row_q;
  logic [RW-1:0]         wr_addr_q;
  logic [BUS_WIDTH-1:0]  data_q;
  logic [RW:0]           issued_q;
  logic [RW:0]           rcv_q;

  logic accept;
  logic req;
  logic rv_ok;

  assign accept = cmd_valid_i && ready_q;
  assign req    = (state_q == FETCH) && (issued_q <= {1'b0, row_q});
  assign rv_ok  = mem_rvalid_i && (state_q == FETCH) && (rcv_q <= {1'b0, row_q});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CFG;
      CFG:     state_d = need_q ? FETCH : DONE;
      FETCH:   if (rv_ok && (rcv_q == {1'b0, row_q})) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A finished tile and a consumed buffer in the same cycle cancel out.
    credits_d = credits_q;
    if ((state_q == DONE) && !bias_loading_done_i)
      credits_d = credits_q + 2'd1;
    else if ((state_q != DONE) && bias_loading_done_i && (credits_q != 2'd0))
      credits_d = credits_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      credits_q <= 2'd0;
      ready_q   <= 1'b0;
      cfg_q     <= 1'b0;
      tile_q    <= 1'b0;
      need_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      row_q     <= '0;
      wr_addr_q <= '0;
      data_q    <= '0;
      issued_q  <= '0;
      rcv_q     <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      ready_q   <= (state_d == IDLE) && (credits_d < 2'd2);
      cfg_q     <= (state_d == CFG);
      tile_q    <= (state_d == DONE);

      if (accept) begin
        addr_q   <= cmd_bias_addr_i;
        row_q    <= cmd_row_num_i;
        need_q   <= cmd_need_bias_i;
        issued_q <= '0;
        rcv_q    <= '0;
      end else if (req && mem_gnt_i) begin
        issued_q <= issued_q + (RW+1)'(1);
      end

      wr_en_q <= rv_ok;
      if (rv_ok) begin
        wr_addr_q <= rcv_q[RW-1:0];
        data_q    <= mem_rdata_i;
        rcv_q     <= rcv_q + (RW+1)'(1);
      end

      // Stray read data is dropped; it and a done with no filled buffer are sticky errors.
      if ((mem_rvalid_i && !rv_ok) || (bias_loading_done_i && (credits_q == 2'd0)))
        err_q <= 1'b1;
    end
  end

  assign cmd_ready_o     = ready_q;
  assign mem_req_o       = req;
  assign mem_addr_o      = req ? (addr_q + ADDR_WIDTH'(issued_q) * ADDR_WIDTH'(NB)) : '0;
  assign init_bias_cfg_o = cfg_q;
  assign valid_row_num_o = row_q;
  assign need_bias_o     = need_q;
  assign bias_wr_en_o    = wr_en_q;
  assign bias_wr_addr_o  = wr_addr_q;
  assign bias_data_o     = data_q;
  assign tile_loaded_o   = tile_q;
  assign busy_o          = (state_q != IDLE);
  assign err_o           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bias_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bias_load_ctrl
// Brief    : Scoreboard bench for bias_load_ctrl with an in-order memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bias_load_ctrl;

  localparam int SIZE = 16;
  localparam int BW   = 32;
  localparam int AW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_bias_addr_i;
  logic [3:0]    cmd_row_num_i;
  logic          cmd_need_bias_i;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [BW-1:0] mem_rdata_i;
  logic          init_bias_cfg_o;
  logic [3:0]    valid_row_num_o;
  logic          need_bias_o;
  logic          bias_wr_en_o;
  logic [3:0]    bias_wr_addr_o;
  logic [BW-1:0] bias_data_o;
  logic          bias_loading_done_i;
  logic          tile_loaded_o;
  logic          busy_o;
  logic          err_o;

  bias_load_ctrl #(.SIZE(SIZE), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid_i         (cmd_valid_i),
    .cmd_ready_o         (cmd_ready_o),
    .cmd_bias_addr_i     (cmd_bias_addr_i),
    .cmd_row_num_i       (cmd_row_num_i),
    .cmd_need_bias_i     (cmd_need_bias_i),
    .mem_req_o           (mem_req_o),
    .mem_addr_o          (mem_addr_o),
    .mem_gnt_i           (mem_gnt_i),
    .mem_rvalid_i        (mem_rvalid_i),
    .mem_rdata_i         (mem_rdata_i),
    .init_bias_cfg_o     (init_bias_cfg_o),
    .valid_row_num_o     (valid_row_num_o),
    .need_bias_o         (need_bias_o),
    .bias_wr_en_o        (bias_wr_en_o),
    .bias_wr_addr_o      (bias_wr_addr_o),
    .bias_data_o         (bias_data_o),
    .bias_loading_done_i (bias_loading_done_i),
    .tile_loaded_o       (tile_loaded_o),
    .busy_o              (busy_o),
    .err_o               (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Scoreboard queues filled by the stimulus, drained by the monitors.
  logic [31:0] exp_addr[$];
  logic [35:0] exp_wr[$];
  logic [4:0]  exp_cfg[$];
  int tiles_exp  = 0;
  int tiles_seen = 0;
  int tile_cyc   = 0;
  int cfg_cyc    = 0;

  // Memory responder: grants, in-order data return, request-side checks.
  int          gnt_mode  = 0;
  int          lat_mode  = 0;
  int          gnt_limit = 1000000;
  int          n_grants  = 0;
  bit          stray     = 1'b0;
  int          pend_due[$];
  logic [31:0] pend_data[$];
  int          last_due  = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin : mem_model
    bit g;
    int due;
    if (rst) begin
      pend_due.delete();
      pend_data.delete();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_gnt_i    = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (stray) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        stray        = 1'b0;
      end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = pend_data.pop_front();
        void'(pend_due.pop_front());
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
      end
      if (prev_stall) begin
        chk("req_held", mem_req_o, 1);
        chk("addr_stable", mem_addr_o, prev_addr);
      end
      g = (n_grants < gnt_limit) && (gnt_mode == 0 || $urandom_range(99) >= 30);
      mem_gnt_i  = g;
      prev_stall = mem_req_o && !g;
      prev_addr  = mem_addr_o;
      if (mem_req_o && g) begin
        n_grants++;
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %0h expected no request", mem_addr_o);
        end else begin
          chk("req_addr", mem_addr_o, exp_addr.pop_front());
        end
        due = cyc + ((lat_mode == 0) ? 1 : int'($urandom_range(4, 1)));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_due.push_back(due);
        pend_data.push_back(mdata(mem_addr_o));
      end
    end
  end

  // Output monitor: bias writes, config pulses, tile completion.
  always @(posedge clk) begin : monitor
    logic [35:0] ew;
    #1;
    if (!rst) begin
      if (bias_wr_en_o) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr: got addr %0h data %0h expected no write", bias_wr_addr_o, bias_data_o);
        end else begin
          ew = exp_wr.pop_front();
          chk("wr_addr", bias_wr_addr_o, ew[35:32]);
          chk("wr_data", bias_data_o, ew[31:0]);
        end
      end
      if (init_bias_cfg_o) begin
        cfg_cyc = cyc;
        if (exp_cfg.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cfg: got row %0h need %0b expected none", valid_row_num_o, need_bias_o);
        end else begin
          chk("cfg_row_need", {valid_row_num_o, need_bias_o}, exp_cfg.pop_front());
        end
      end
      if (tile_loaded_o) begin
        tile_cyc = cyc;
        chk("tile_pending", tiles_seen < tiles_exp, 1);
        chk("tile_all_written", exp_wr.size(), 0);
        tiles_seen++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [3:0] row, input bit need, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready_o, 1);
    cmd_valid_i     = 1'b1;
    cmd_bias_addr_i = a;
    cmd_row_num_i   = row;
    cmd_need_bias_i = need;
    exp_cfg.push_back({row, need});
    tiles_exp++;
    if (need) begin
      for (int i = 0; i <= int'(row); i++) begin
        exp_addr.push_back(a + 32'(i * 4));
        exp_wr.push_back({4'(i), mdata(a + 32'(i * 4))});
      end
    end
    acc = cyc;
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_tile(input int n);
    int t;
    t = 0;
    while (tiles_seen < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("tile_wait", tiles_seen >= n, 1);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    bias_loading_done_i = 1'b1;
    @(negedge clk);
    bias_loading_done_i = 1'b0;
  endtask

  initial begin : stim
    int acc;
    int t;
    rst = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_bias_addr_i = '0;
    cmd_row_num_i = '0;
    cmd_need_bias_i = 1'b0;
    bias_loading_done_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_wr", bias_wr_en_o, 0);

    // Four rows at 0x100, always granted, one-cycle latency.
    send(32'h100, 4'd3, 1'b1, acc);
    wait_tile(1);
    @(negedge clk);
    chk("t1_ready_credit1", cmd_ready_o, 1);
    chk("t1_idle", busy_o, 0);

    // Second tile fills both buffers; one done frees one.
    send(32'h200, 4'd1, 1'b1, acc);
    wait_tile(2);
    @(negedge clk);
    chk("full_ready_low", cmd_ready_o, 0);
    pulse_done();
    chk("freed_ready_high", cmd_ready_o, 1);
    pulse_done();

    // No bias needed: config pulse only, tile two cycles after accept.
    send(32'h300, 4'd15, 1'b0, acc);
    wait_tile(3);
    chk("nobias_cfg_cyc", cfg_cyc, acc + 1);
    chk("nobias_tile_cyc", tile_cyc, acc + 2);
    pulse_done();

    // Stalled grants and variable latency.
    gnt_mode = 1;
    lat_mode = 1;
    send(32'h1000, 4'd15, 1'b1, acc);
    wait_tile(4);
    pulse_done();
    gnt_mode = 0;
    lat_mode = 0;

    // Address wraps past the top of the address space.
    send(32'hFFFF_FFF8, 4'd3, 1'b1, acc);
    wait_tile(5);
    pulse_done();

    // Done coincident with DONE at credits=1 leaves credits at 1.
    send(32'h400, 4'd0, 1'b0, acc);
    wait_tile(6);
    send(32'h500, 4'd0, 1'b0, acc);
    @(negedge clk);
    bias_loading_done_i = 1'b1;
    @(negedge clk);
    bias_loading_done_i = 1'b0;
    wait_tile(7);
    chk("coinc_tile_cyc", tile_cyc, acc + 2);
    chk("coinc_ready", cmd_ready_o, 1);
    chk("coinc_no_err", err_o, 0);
    send(32'h600, 4'd0, 1'b0, acc);
    wait_tile(8);
    @(negedge clk);
    chk("coinc_credits_two", cmd_ready_o, 0);
    pulse_done();
    pulse_done();
    chk("drain_no_err", err_o, 0);

    // Done coincident with DONE at credits=0 flags an error.
    send(32'h700, 4'd0, 1'b0, acc);
    @(negedge clk);
    bias_loading_done_i = 1'b1;
    @(negedge clk);
    bias_loading_done_i = 1'b0;
    chk("credit0_err", err_o, 1);

    // Reset in the middle of a fetch, then a stray read return.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_err_clear", err_o, 0);
    gnt_limit = n_grants + 5;
    send(32'h2000, 4'd15, 1'b1, acc);
    t = 0;
    while (n_grants < gnt_limit && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("five_grants", n_grants, gnt_limit);
    repeat (4) @(negedge clk);
    chk("mid_busy", busy_o, 1);
    chk("mid_req", mem_req_o, 1);
    rst = 1'b1;
    exp_addr.delete();
    exp_wr.delete();
    exp_cfg.delete();
    tiles_exp--;
    @(negedge clk);
    chk("rst_mid_req", mem_req_o, 0);
    chk("rst_mid_addr", mem_addr_o, 0);
    chk("rst_mid_wr", bias_wr_en_o, 0);
    chk("rst_mid_data", bias_data_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_ready", cmd_ready_o, 0);
    chk("rst_mid_row", valid_row_num_o, 0);
    @(negedge clk);
    rst = 1'b0;
    gnt_limit = 1000000;
    @(negedge clk);
    chk("rel_ready", cmd_ready_o, 1);
    chk("rel_err", err_o, 0);
    stray = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_err", err_o, 1);
    chk("stray_no_wr", bias_wr_en_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL global_timeout: got no completion expected finish before 500us");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bias_load_ctrl.md
BIAS_LOAD_CTRL -- requirements
Module: bias_load_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 16: bias rows per tile, matching the bias adder.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: memory read-data and bias word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-004 SHALL have these ports, with one clock and a synchronous active-high reset:
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid_i  in  1  tile command valid.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_bias_addr_i  in  ADDR_WIDTH  byte base address of bias words; low bits are zero, word-aligned.
- cmd_row_num_i  in  $clog2(SIZE)  rows-1 (0 means 1 row).
- cmd_need_bias_i  in  1  tile needs bias.
- mem_req_o  out  1  read request.
- mem_addr_o  out  ADDR_WIDTH  read byte address.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid, in order.
- mem_rdata_i  in  BUS_WIDTH  read data.
- init_bias_cfg_o  out  1  one-cycle config pulse to adder.
- valid_row_num_o  out  $clog2(SIZE)  registered row number.
- need_bias_o  out  1  registered need_bias.
- bias_wr_en_o  out  1  bias buffer write.
- bias_wr_addr_o  out  $clog2(SIZE)  bias row index.
- bias_data_o  out  BUS_WIDTH  bias word.
- bias_loading_done_i  in  1  adder finished one tile; frees one buffer.
- tile_loaded_o  out  1  one-cycle pulse when a tile's bias is fully written.
- busy_o  out  1  FSM not IDLE.
- err_o  out  1  sticky protocol error.

Function
REQ-005 SHALL use FSM states IDLE, CFG, FETCH, DONE.
REQ-006 cmd_ready_o SHALL equal (state==IDLE && credits<2); credits is a 2-bit count of filled, unconsumed buffers.
REQ-007 On command accept, SHALL latch addr, row_num and need_bias and go to CFG next cycle.
REQ-008 In CFG, SHALL assert init_bias_cfg_o for exactly one cycle with valid_row_num_o/need_bias_o already holding latched values; next state is FETCH if need_bias else DONE.
REQ-009 In FETCH, SHALL assert mem_req_o while issued < row_num+1, with mem_addr_o = base + issued*(BUS_WIDTH/8); issued increments on mem_gnt_i; addr and req stay stable until granted.
REQ-010 SHALL support multiple outstanding reads: a request may be granted in the same cycle that an earlier read's data returns.
REQ-011 On each mem_rvalid_i in FETCH, SHALL assert bias_wr_en_o one cycle later with bias_wr_addr_o = received index (0..row_num) and bias_data_o = registered rdata; received then increments.
REQ-012 SHALL go FETCH -> DONE in the cycle the final write (index row_num) is driven.
REQ-013 DONE SHALL last one cycle: pulse tile_loaded_o, credits+1, then return to IDLE.
REQ-014 need_bias=0 tiles SHALL still consume a credit (the adder alternates buffers per tile) but issue no reads or writes.
REQ-015 credits SHALL decrement on bias_loading_done_i; if DONE coincides with it, credits stay unchanged.
REQ-016 bias_loading_done_i while credits==0 SHALL set err_o; credits stay 0.
REQ-017 mem_rvalid_i outside FETCH, or with received > row_num, SHALL set err_o and be dropped.
REQ-018 err_o SHALL clear only on reset.
REQ-019 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-020 When rst is sampled high, SHALL enter IDLE and zero credits, issued, received, latches and all outputs; cmd_ready_o reads 1 the cycle after release.
REQ-021 Reset mid-FETCH SHALL abandon outstanding reads; late rvalid after release sets err_o (REQ-017).

Structure
REQ-022 FSM state enum SHALL live in the shared accelerator package.
REQ-023 Width helper localparams (ROW_W=$clog2(SIZE), BYTES=BUS_WIDTH/8) SHALL live in the same package.
REQ-024 SHALL be a single module with no sub-modules; it instantiates alongside the bias adder and connects directly to its config/write/done ports.

Verification
REQ-025 Row_num=3, base 0x100, gnt always 1, rvalid 1 cycle later: reads 0x100,0x104,0x108,0x10C; writes addr 0..3 with matching data; tile_loaded_o pulses once; credits=1.
REQ-026 Two tiles accepted with no bias_loading_done_i: cmd_ready_o goes 0; one bias_loading_done_i pulse -> cmd_ready_o=1 next cycle.
REQ-027 need_bias=0, row_num=15: init_bias_cfg_o pulses, zero mem_req_o/bias_wr_en_o, tile_loaded_o pulses 2 cycles after accept.
REQ-028 Random gnt stalls (30%), rvalid latency 1-4 cycles, row_num=15: 16 in-order writes, mem_addr_o stable while ungranted.
REQ-029 DONE coincident with bias_loading_done_i at credits=1: credits remain 1; done at credits=0: err_o=1.
REQ-030 rst asserted mid-FETCH after 5 of 16 reads: all outputs 0 next cycle, FSM IDLE, later stray rvalid sets err_o.
